// File: rtl/data_mem_bridge_if.sv
// Request/response bus between the data-memory bridge and the memory slave.
// The bridge owns the request phase; the slave owns ready and read data.
interface data_mem_bridge_if;
  logic        valid;
  logic        ready;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output valid, we, addr, be, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, addr, be, wdata,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/data_mem_bridge.sv
// Data-memory bridge: turns the core memory-stage request into one bus
// transaction and freezes the pipeline until it completes or times out.
module data_mem_bridge #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_be,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        mem_err,
  data_mem_bridge_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        start;
  logic        skip;
  logic        hs;
  logic        got;
  logic        busy;
  logic        expire;
  logic        cnt_clr;
  logic        cnt_inc;
  logic        cap_req;
  logic        cap_rd;

  assign start = (state == IDLE) & mem_req
               & (~mem_we | (|mem_be));
  assign skip  = (state == IDLE) & mem_req
               & mem_we & ~(|mem_be);
  assign hs    = (state == ADDR) & bus.ready;
  assign got   = (state == RESP) & bus.rvalid;
  assign busy  = (state == ADDR) | (state == RESP);
  // >= so a read that wins the race at the last ADDR
  // cycle still times out if RESP then stalls.
  assign expire = busy & (cnt >= TMO_LAST)
                & ~hs & ~got;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (skip) begin
          state_nxt = DONE;
        end else if (start) begin
          state_nxt = ADDR;
        end
      end
      ADDR: begin
        if (hs) begin
          state_nxt = we_q ? DONE : RESP;
        end else if (expire) begin
          state_nxt = DONE;
        end
      end
      RESP: begin
        if (got || expire) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    mem_stall = 1'b0;
    bus.valid = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    cap_req   = 1'b0;
    cap_rd    = 1'b0;
    unique case (state)
      IDLE: begin
        mem_stall = mem_req;
        cnt_clr   = start;
        cap_req   = start;
      end
      ADDR: begin
        mem_stall = 1'b1;
        bus.valid = 1'b1;
        cnt_inc   = 1'b1;
      end
      RESP: begin
        mem_stall = 1'b1;
        cnt_inc   = 1'b1;
        cap_rd    = bus.rvalid;
      end
      DONE: begin
        mem_stall = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (1'b1)
        cnt_clr: cnt <= '0;
        cnt_inc: cnt <= cnt + 8'd1;
        default: cnt <= cnt;
      endcase
      if (cap_req) begin
        we_q    <= mem_we;
        addr_q  <= mem_addr & ~32'd3;
        be_q    <= mem_we ? mem_be : 4'b1111;
        wdata_q <= mem_wdata;
      end
      if (cap_rd) begin
        rdata_q <= bus.rdata;
      end else if (expire) begin
        rdata_q <= '0;
      end
      // Registered so the flag lines up with the DONE cycle.
      err_q <= expire;
    end
  end

  assign bus.we    = we_q;
  assign bus.addr  = addr_q;
  assign bus.be    = be_q;
  assign bus.wdata = wdata_q;
  assign mem_rdata = rdata_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
// Bench for data_mem_bridge: directed corner cases then random
// transactions against a transaction-level outcome model.
module tb_data_mem_bridge;

  localparam int T = 16;

  logic        clk;
  logic        rst;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        mem_err;

  int tests;
  int failed;
  logic [31:0] model_rdata;

  data_mem_bridge_if bus ();

  data_mem_bridge #(.TIMEOUT(T)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_stall (mem_stall),
    .mem_err   (mem_err),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // d: ADDR cycles without ready before the ready cycle.
  // r: RESP cycles without rvalid before the rvalid cycle.
  task automatic txn(input string tag,
                     input logic we,
                     input logic [31:0] addr,
                     input logic [3:0] be,
                     input logic [31:0] wd,
                     input int d,
                     input int r,
                     input logic [31:0] rd);
    int stalls;
    int vcnt;
    int rcnt;
    int e_stall;
    int e_valid;
    logic e_err;
    logic [31:0] e_addr;
    logic [3:0] e_be;
    logic in_resp;
    logic resp_next;
    logic fields_ok;
    logic done_seen;

    e_addr = {addr[31:2], 2'b00};
    e_be   = we ? be : 4'b1111;
    if (we && be == 4'd0) begin
      e_stall = 1; e_valid = 0; e_err = 1'b0;
    end else if (d >= T) begin
      e_stall = T + 1; e_valid = T; e_err = 1'b1;
      model_rdata = '0;
    end else if (we) begin
      e_stall = d + 2; e_valid = d + 1; e_err = 1'b0;
    end else if (d + 1 + r <= T - 1) begin
      e_stall = d + r + 3; e_valid = d + 1; e_err = 1'b0;
      model_rdata = rd;
    end else begin
      e_stall = T + 1; e_valid = d + 1; e_err = 1'b1;
      model_rdata = '0;
    end

    stalls = 0; vcnt = 0; rcnt = 0;
    in_resp = 1'b0; resp_next = 1'b0;
    fields_ok = 1'b1; done_seen = 1'b0;

    @(negedge clk);
    mem_req = 1'b1; mem_we = we; mem_addr = addr;
    mem_be = be; mem_wdata = wd;
    for (int c = 0; c < 80; c++) begin
      in_resp = in_resp | resp_next;
      resp_next = 1'b0;
      bus.ready = 1'b0;
      bus.rvalid = 1'b0;
      bus.rdata = $urandom;
      if (bus.valid) begin
        if (bus.we !== we || bus.addr !== e_addr ||
            bus.be !== e_be || (we && bus.wdata !== wd))
          fields_ok = 1'b0;
        bus.ready = (vcnt == d);
        bus.rvalid = 1'($urandom_range(0, 1));
        resp_next = bus.ready & ~we;
        vcnt++;
      end else if (in_resp) begin
        bus.rvalid = (rcnt == r);
        bus.rdata = rd;
        rcnt++;
      end
      #1;
      if (!mem_stall) begin
        done_seen = 1'b1;
        break;
      end
      stalls++;
      @(negedge clk);
    end

    check({tag, ".done"}, 32'(done_seen), 32'd1);
    check({tag, ".stall"}, 32'(stalls), 32'(e_stall));
    check({tag, ".valid"}, 32'(vcnt), 32'(e_valid));
    check({tag, ".fields"}, 32'(fields_ok), 32'd1);
    check({tag, ".err"}, 32'(mem_err), 32'(e_err));
    check({tag, ".rdata"}, mem_rdata, model_rdata);

    @(negedge clk);
    mem_req = 1'b0;
    bus.ready = 1'b0;
    bus.rvalid = 1'b0;
    #1;
    check({tag, ".idle"},
          {29'd0, mem_err, mem_stall, bus.valid}, 32'd0);
  endtask

  initial begin
    tests = 0;
    failed = 0;
    model_rdata = '0;
    clk = 1'b0;
    rst = 1'b1;
    mem_req = 1'b0;
    mem_we = 1'b0;
    mem_addr = '0;
    mem_be = '0;
    mem_wdata = '0;
    bus.ready = 1'b0;
    bus.rvalid = 1'b0;
    bus.rdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst.stall", 32'(mem_stall), 32'd0);
    check("rst.valid", 32'(bus.valid), 32'd0);
    check("rst.err", 32'(mem_err), 32'd0);
    check("rst.rdata", mem_rdata, 32'd0);
    check("rst.addr", bus.addr, 32'd0);
    check("rst.be", 32'(bus.be), 32'd0);

    txn("read", 1'b0, 32'h0000_1006, 4'h0, 32'h0,
        0, 0, 32'hA5A5_1234);
    check("read.bus_addr", bus.addr, 32'h0000_1004);
    check("read.bus_be", 32'(bus.be), 32'hF);

    txn("write", 1'b1, 32'h0000_0020, 4'b0011,
        32'h0000_BEEF, 4, 0, 32'h0);
    txn("tmo", 1'b0, 32'h0000_0100, 4'h0, 32'h0,
        1000, 0, 32'h1111_2222);
    txn("zstore", 1'b1, 32'h0000_0200, 4'h0,
        32'hCAFE_0000, 0, 0, 32'h0);
    txn("edge_rd", 1'b0, 32'h0000_0300, 4'h0, 32'h0,
        0, T - 2, 32'h5A5A_0F0F);
    txn("late_rd", 1'b0, 32'h0000_0304, 4'h0, 32'h0,
        0, T - 1, 32'h7777_8888);
    txn("edge_wr", 1'b1, 32'h0000_0400, 4'b1000,
        32'h1200_0000, T - 1, 0, 32'h0);
    txn("tmo_wr", 1'b1, 32'h0000_0404, 4'b0100,
        32'h0034_0000, T, 0, 32'h0);
    txn("pre_rst", 1'b0, 32'h0000_0500, 4'h0, 32'h0,
        1, 2, 32'h0BAD_F00D);

    // Reset while waiting in RESP, then a stray rvalid.
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0;
    mem_addr = 32'h0000_0044; mem_be = 4'h0;
    @(negedge clk);
    bus.ready = 1'b1;
    @(negedge clk);
    bus.ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mem_req = 1'b0;
    #1;
    check("mid.stall_before", 32'(mem_stall), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    bus.rvalid = 1'b1;
    bus.rdata = 32'hDEAD_BEEF;
    #1;
    check("mid.valid", 32'(bus.valid), 32'd0);
    check("mid.stall", 32'(mem_stall), 32'd0);
    check("mid.addr", bus.addr, 32'd0);
    @(negedge clk);
    bus.rvalid = 1'b0;
    model_rdata = '0;
    #1;
    check("mid.rdata", mem_rdata, model_rdata);
    check("mid.err", 32'(mem_err), 32'd0);

    for (int i = 0; i < 40; i++) begin
      logic we;
      logic [3:0] be;
      int d;
      int r;
      we = 1'($urandom_range(0, 1));
      be = 4'($urandom_range(0, 15));
      d = $urandom_range(0, T + 2);
      r = $urandom_range(0, T);
      if (!we && d == T - 1) d = T - 2;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      txn($sformatf("rnd%0d", i), we, $urandom, be,
          $urandom, d, r, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/data_mem_bridge.md
DATA_MEM_BRIDGE -- requirements
Module: data_mem_bridge

Interface
REQ-001 Parameter TIMEOUT, default 16, sets the number of cycles spent in ADDR+RESP before a transaction is aborted; legal range 2..255.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 mem_req  in  1  core memory-stage request, held while mem_stall=1.
REQ-006 mem_we  in  1  1=store, 0=load.
REQ-007 mem_addr  in  32  byte address from the core ALU result.
REQ-008 mem_be  in  4  store byte enables, already lane-aligned.
REQ-009 mem_wdata  in  32  store data, already lane-rotated.
REQ-010 mem_rdata  out  32  load word returned to the core.
REQ-011 mem_stall  out  1  freeze request to the core hazard logic.
REQ-012 mem_err  out  1  one-cycle flag: the access timed out.
REQ-013 bus_valid  out  1  request phase valid.
REQ-014 bus_ready  in  1  slave accepts the request phase.
REQ-015 bus_we, bus_addr[31:0], bus_be[3:0], bus_wdata[31:0]  out  registered request fields.
REQ-016 bus_rvalid  in  1  read data valid.
REQ-017 bus_rdata  in  32  read data.

Function
REQ-018 The FSM SHALL have the states IDLE, ADDR, RESP and DONE, encoded in 2 bits.
REQ-019 IDLE with mem_req=1 and (mem_we=0 or mem_be!=0): capture we/addr/be/wdata, go to ADDR.
REQ-020 IDLE with mem_req=1, mem_we=1, mem_be=0: go directly to DONE with no bus transaction.
REQ-021 mem_stall SHALL equal (state==IDLE & mem_req) | state==ADDR | state==RESP, combinationally, so the request cycle itself stalls the core.
REQ-022 In ADDR, bus_valid=1 and request fields are stable until the bus_ready handshake cycle.
REQ-023 In ADDR, bus_ready=1 with a write goes to DONE; bus_ready=1 with a read goes to RESP.
REQ-024 In RESP, bus_rvalid=1 captures bus_rdata into the rdata register and goes to DONE; bus_rvalid is ignored in every other state.
REQ-025 bus_addr SHALL be {addr[31:2],2'b00}; bus_be = captured be for writes and 4'b1111 for reads.
REQ-026 A timeout counter SHALL clear on entry to ADDR and increment every cycle in ADDR or RESP.
REQ-027 When the counter reaches TIMEOUT-1 without completion, the FSM SHALL go to DONE, clear rdata to 0, and flag an error.
REQ-028 If the counter reaches TIMEOUT-1 in the same cycle that the handshake completes, the handshake SHALL win and no error is flagged.
REQ-029 DONE SHALL last exactly 1 cycle: mem_stall=0, mem_err=1 only if a timeout occurred, then return to IDLE.
REQ-030 mem_rdata SHALL hold the last captured value until the next read capture or timeout.
REQ-031 A request arriving in IDLE on the cycle after DONE SHALL start a new transaction; no back-to-back merging.
REQ-032 Minimum latency: read = 3 stall cycles (ready immediate, rvalid the next cycle); write = 2 stall cycles.

Reset
REQ-033 rst=1 SHALL force state=IDLE, counter=0, bus_valid=0, mem_err=0, mem_rdata=0 and all bus request fields to 0 on the next edge, including mid-transaction.
REQ-034 A bus_rvalid that arrives after a mid-transaction reset SHALL be ignored.

Verification
REQ-035 Read: mem_addr=0x0000_1006, mem_we=0, bus_ready=1, bus_rvalid the next cycle with 0xA5A5_1234 -> bus_addr=0x0000_1004, bus_be=1111, 3 stall cycles, mem_rdata=0xA5A5_1234, mem_err=0.
REQ-036 Write: mem_addr=0x20, mem_be=0011, mem_wdata=0x0000_BEEF, bus_ready delayed 4 cycles -> bus fields stable for 5 cycles, stall for 6 cycles, no RESP state.
REQ-037 Timeout: TIMEOUT=16, bus_ready stuck at 0 -> DONE after 16 ADDR cycles, mem_err pulses 1 cycle, mem_rdata=0.
REQ-038 Zero-byte store: mem_we=1, mem_be=0000 -> bus_valid never asserts, 1 stall cycle, then DONE.
REQ-039 Reset mid-RESP: assert rst while waiting for rvalid, then drive rvalid=1 -> IDLE, mem_rdata stays 0, bus_valid=0.
REQ-040 Boundary: bus_rvalid arrives exactly on counter=TIMEOUT-1 -> data captured, mem_err=0.
